// File: rtl/lut_log_offset_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_log_offset_prog_if
// Brief    : Config-stream and lookup handshake bundle for lut_log_offset_prog.
// Revision : 1.0
// ============================================================================
interface lut_log_offset_prog_if #(
   parameter int IDX_W  = 4,
   parameter int DATA_W = 24,
   parameter int NUM_CH = 2
);
   logic                       cfg_start;
   logic                       cfg_valid;
   logic [DATA_W-1:0]          cfg_data;
   logic                       cfg_busy;
   logic                       tbl_ready;
   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_CH*IDX_W-1:0]    in_idx;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_CH*DATA_W-1:0]   out_data;

   modport master (
      output cfg_start, cfg_valid, cfg_data, in_valid, in_idx, out_ready,
      input  cfg_busy, tbl_ready, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, in_valid, in_idx, out_ready,
      output cfg_busy, tbl_ready, in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/lut_log_offset_prog.sv
`default_nettype none
// ============================================================================
// Module   : lut_log_offset_prog
// Brief    : Runtime-programmable, multi-lane, clamped log-offset lookup table.
// Revision : 1.0
// ============================================================================
module lut_log_offset_prog #(
   parameter int IDX_W     = 4,
   parameter int DATA_W    = 24,
   parameter int NUM_CH    = 2,
   parameter int CLAMP_IDX = 14
) (
   input  wire logic             clock,
   input  wire logic             rst_n,
   lut_log_offset_prog_if.slave  bus
);
   localparam int               DEPTH   = 2**IDX_W;
   localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(DEPTH-1);
   localparam logic [IDX_W-1:0] c_CLAMP = IDX_W'(CLAMP_IDX);
   localparam logic [IDX_W-1:0] c_ONE   = IDX_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t                     r_state;
   logic [IDX_W-1:0]           r_ptr;
   logic [DATA_W-1:0]          r_tbl [DEPTH];
   logic                       r_cfg_busy;
   logic                       r_tbl_ready;
   logic                       r_out_valid;
   logic [NUM_CH*DATA_W-1:0]   r_out_data;

   logic                       w_in_ready;
   logic                       w_accept;
   logic [NUM_CH*DATA_W-1:0]   w_lookup;

   assign w_in_ready = (r_state == S_ACTIVE) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.cfg_busy  = r_cfg_busy;
   assign bus.tbl_ready = r_tbl_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

   // Each lane saturates its own index before reading the shared table.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [IDX_W-1:0] w_idx_raw;
      logic [IDX_W-1:0] w_idx;
      assign w_idx_raw = bus.in_idx[k*IDX_W +: IDX_W];
      assign w_idx     = (w_idx_raw > c_CLAMP) ? c_CLAMP : w_idx_raw;
      assign w_lookup[k*DATA_W +: DATA_W] = r_tbl[w_idx];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_cfg_busy  <= 1'b0;
         r_tbl_ready <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_tbl[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cfg_start) begin
                  r_state    <= S_LOAD;
                  r_ptr      <= '0;
                  r_cfg_busy <= 1'b1;
               end
            end
            S_LOAD: begin
               // A restart wins over any beat presented alongside it.
               if (bus.cfg_start) begin
                  r_ptr <= '0;
               end else if (bus.cfg_valid) begin
                  r_tbl[r_ptr] <= bus.cfg_data;
                  r_ptr        <= r_ptr + c_ONE;
                  if (r_ptr == c_LAST) begin
                     r_state     <= S_ACTIVE;
                     r_cfg_busy  <= 1'b0;
                     r_tbl_ready <= 1'b1;
                  end
               end
            end
            S_ACTIVE: begin
               if (bus.cfg_start) begin
                  r_state     <= S_LOAD;
                  r_ptr       <= '0;
                  r_cfg_busy  <= 1'b1;
                  r_tbl_ready <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cfg_busy  <= 1'b0;
               r_tbl_ready <= 1'b0;
            end
         endcase
      end
   end

   // Result register: data is only replaced on accept, never cleared on drain.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_lookup;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lut_log_offset_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_log_offset_prog
// Brief    : Randomized and directed self-checking bench for lut_log_offset_prog.
// Revision : 1.0
// ============================================================================
module tb_lut_log_offset_prog;
   localparam int IDX_W     = 4;
   localparam int DATA_W    = 24;
   localparam int NUM_CH    = 2;
   localparam int CLAMP_IDX = 14;
   localparam int DEPTH     = 16;

   logic clock;
   logic rst_n;

   lut_log_offset_prog_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

   lut_log_offset_prog #(
      .IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CLAMP_IDX(CLAMP_IDX)
   ) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: mode 0 = idle, 1 = loading, 2 = table usable.
   int                       m_mode;
   int                       m_ptr;
   logic [DATA_W-1:0]        m_tbl [DEPTH];
   logic                     m_ov;
   logic [NUM_CH*DATA_W-1:0] m_od;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic exp_in_ready();
      return (m_mode == 2) && (!m_ov || bus.out_ready);
   endfunction

   function automatic int clamp(input int idx);
      return (idx > CLAMP_IDX) ? CLAMP_IDX : idx;
   endfunction

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0;
         m_ptr  <= 0;
         m_ov   <= 1'b0;
         m_od   <= '0;
         for (int i = 0; i < DEPTH; i++) m_tbl[i] <= '0;
      end else begin
         if (bus.in_valid && exp_in_ready()) begin
            m_ov <= 1'b1;
            for (int k = 0; k < NUM_CH; k++)
               m_od[k*DATA_W +: DATA_W] <= m_tbl[clamp(int'(bus.in_idx[k*IDX_W +: IDX_W]))];
         end else if (bus.out_ready) begin
            m_ov <= 1'b0;
         end
         if (bus.cfg_start) begin
            m_mode <= 1;
            m_ptr  <= 0;
         end else if (m_mode == 1 && bus.cfg_valid) begin
            m_tbl[m_ptr] <= bus.cfg_data;
            m_ptr        <= (m_ptr + 1) % DEPTH;
            if (m_ptr == DEPTH-1) m_mode <= 2;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("cfg_busy",  64'(bus.cfg_busy),  64'(m_mode == 1));
      chk("tbl_ready", 64'(bus.tbl_ready), 64'(m_mode == 2));
      chk("in_ready",  64'(bus.in_ready),  64'(exp_in_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("out_data",  64'(bus.out_data),  64'(m_od));
   endtask

   // One clock of stimulus: drive at the falling edge, then check against the model.
   task automatic step(input logic rn, input logic st, input logic cv, input logic [23:0] cd,
                       input logic iv, input logic [7:0] idx, input logic orr);
      @(negedge clock);
      rst_n         = rn;
      bus.cfg_start = st;
      bus.cfg_valid = cv;
      bus.cfg_data  = cd;
      bus.in_valid  = iv;
      bus.in_idx    = idx;
      bus.out_ready = orr;
      #2;
      compare_all();
   endtask

   task automatic load_table(input logic [23:0] base);
      step(1, 1, 1, 24'hDEAD00, 1, 8'h21, 1);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 4 || i == 9) step(1, 0, 0, 24'h0, 1, 8'h11, 1);
         step(1, 0, 1, base + 24'(i), 1, 8'(i), 1);
      end
      chk("ready_low_at_last_beat", 64'(bus.tbl_ready), 64'd0);
      chk("busy_high_at_last_beat", 64'(bus.cfg_busy), 64'd1);
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("ready_after_load", 64'(bus.tbl_ready), 64'd1);
      chk("busy_after_load",  64'(bus.cfg_busy),  64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = '0;
      bus.in_valid = 0;  bus.in_idx = '0;   bus.out_ready = 0;

      repeat (3) step(0, 0, 0, 24'h0, 0, 8'h0, 0);
      chk("reset_out_data",  64'(bus.out_data),  64'd0);
      chk("reset_tbl_ready", 64'(bus.tbl_ready), 64'd0);

      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 24'h0, 1, 8'h35, 1);
         chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
      end

      load_table(24'h100000);

      step(1, 0, 0, 24'h0, 1, {4'd3, 4'd15}, 1);
      chk("accept_ready", 64'(bus.in_ready), 64'd1);
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("clamp_valid", 64'(bus.out_valid), 64'd1);
      chk("clamp_data",  64'(bus.out_data), {16'h0, 24'h100003, 24'h10000E});

      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 24'h0, 1, {4'd0, 4'(i)}, 1);
         if (i > 0) chk("b2b_lane0", 64'(bus.out_data[23:0]), 64'(24'h100000 + 24'(i-1)));
      end
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("b2b_last", 64'(bus.out_data[23:0]), 64'h100005);

      step(1, 0, 0, 24'h0, 1, {4'd0, 4'd7}, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 24'h0, 1, {4'd0, 4'd9}, 0);
         chk("stall_data",  64'(bus.out_data[23:0]), 64'h100007);
         chk("stall_ready", 64'(bus.in_ready), 64'd0);
      end
      step(1, 0, 0, 24'h0, 1, {4'd0, 4'd9}, 1);
      chk("release_ready", 64'(bus.in_ready), 64'd1);
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("release_data", 64'(bus.out_data[23:0]), 64'h100009);

      load_table(24'hABC000);
      step(1, 0, 0, 24'h0, 1, {4'd2, 4'd2}, 1);
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("reload_data", 64'(bus.out_data), {16'h0, 24'hABC002, 24'hABC002});

      for (int i = 0; i < 1500; i++) begin
         step(1, ($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1),
              24'($urandom), ($urandom_range(0, 9) < 7), 8'($urandom),
              ($urandom_range(0, 3) != 0));
      end

      step(1, 1, 0, 24'h0, 0, 8'h0, 1);
      for (int i = 0; i < 7; i++) step(1, 0, 1, 24'h700000 + 24'(i), 0, 8'h0, 1);
      step(0, 0, 1, 24'h777777, 1, 8'h0, 1);
      chk("midload_rst_data",  64'(bus.out_data),  64'd0);
      chk("midload_rst_busy",  64'(bus.cfg_busy),  64'd0);
      chk("midload_rst_valid", 64'(bus.out_valid), 64'd0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, 24'h123456, 1, 8'h55, 1);
         chk("post_rst_ready", 64'(bus.in_ready), 64'd0);
      end
      load_table(24'h5A0000);
      step(1, 0, 0, 24'h0, 1, {4'd12, 4'd5}, 1);
      step(1, 0, 0, 24'h0, 0, 8'h0, 1);
      chk("final_data", 64'(bus.out_data), {16'h0, 24'h5A000C, 24'h5A0005});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
